// File: rtl/hart_bus_ctrl.sv
// Responder for the hart line bus: one line transfer at a time onto a single memory port,
// write invalidation broadcast, and an exclusive AMO lock. Optional macro: HBC_RR_ARB_EN (round-robin arbitration).
module hart_bus_ctrl #(
    parameter int NHART  = 2,
    parameter int LINE_W = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [64*NHART-1:0]     h_addr,
    input  logic [NHART-1:0]        h_rd,
    input  logic [NHART-1:0]        h_wr,
    input  logic [LINE_W*NHART-1:0] h_data_out,
    output logic [LINE_W-1:0]       h_data_in,
    output logic [NHART-1:0]        h_dv,
    output logic [63:0]             h_inv_addr,
    output logic [NHART-1:0]        h_inv,
    input  logic [NHART-1:0]        h_amo_req,
    output logic [NHART-1:0]        h_amo_ack,
    output logic [63:0]             m_addr,
    output logic                    m_rd,
    output logic                    m_wr,
    output logic [LINE_W-1:0]       m_wdata,
    input  logic [LINE_W-1:0]       m_rdata,
    input  logic                    m_ack,
    output logic [1:0]              o_dbg_state
);

    localparam int IDX_W = (NHART > 1) ? $clog2(NHART) : 1;
    localparam logic [63:0] ALIGN_MASK = ~(64'(LINE_W / 8) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Returns {found, index}: first requester at or after ptr, wrapping around.
    function automatic logic [IDX_W:0] f_pick(input logic [NHART-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NHART; k++) begin
            j = (int'(ptr) + k) % NHART;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [NHART-1:0] f_oh(input logic [IDX_W-1:0] idx);
        logic [NHART-1:0] v;
        v = '0;
        for (int k = 0; k < NHART; k++) begin
            if (int'(idx) == k) v[k] = 1'b1;
        end
        return v;
    endfunction

    state_t             r_state;
    logic [IDX_W-1:0]   r_g;
    logic               r_op_wr;
    logic [63:0]        r_addr;
    logic [LINE_W-1:0]  r_wdata;
    logic               r_rd;
    logic               r_wr;
    logic [LINE_W-1:0]  r_line;
    logic [NHART-1:0]   r_dv;
    logic [NHART-1:0]   r_inv;
    logic [63:0]        r_inv_addr;
    logic               r_own_vld;
    logic [IDX_W-1:0]   r_own;
    logic [NHART-1:0]   r_ack;

    logic [IDX_W-1:0]   w_ptr;
    logic               w_lock_held;
    logic [NHART-1:0]   w_line_req;
    logic [NHART-1:0]   w_elig;
    logic [IDX_W:0]     w_line_pick;
    logic               w_line_vld;
    logic [IDX_W-1:0]   w_line_g;
    logic [IDX_W:0]     w_amo_pick;
    logic               w_amo_grant;
    logic [IDX_W-1:0]   w_amo_g;
    logic [63:0]        w_req_addr;

`ifdef HBC_RR_ARB_EN
    logic [IDX_W-1:0]   r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // A lock whose owner has just dropped its request no longer blocks anyone this cycle.
    assign w_lock_held = r_own_vld & h_amo_req[r_own];
    assign w_line_req  = h_rd | h_wr;
    assign w_elig      = w_lock_held ? (w_line_req & f_oh(r_own)) : w_line_req;
    assign w_line_pick = f_pick(w_elig, w_ptr);
    assign w_line_vld  = w_line_pick[IDX_W];
    assign w_line_g    = w_line_pick[IDX_W-1:0];
    assign w_amo_pick  = f_pick(h_amo_req, w_ptr);
    assign w_amo_g     = w_amo_pick[IDX_W-1:0];
    assign w_amo_grant = w_amo_pick[IDX_W] && !w_lock_held &&
                         (r_state == S_IDLE || r_state == S_GAP);
    assign w_req_addr  = h_addr[64*int'(w_line_g) +: 64] & ALIGN_MASK;

    assign h_data_in   = r_line;
    assign h_dv        = r_dv;
    assign h_inv       = r_inv;
    assign h_inv_addr  = r_inv_addr;
    assign h_amo_ack   = r_ack & h_amo_req;
    assign m_addr      = r_addr;
    assign m_rd        = r_rd;
    assign m_wr        = r_wr;
    assign m_wdata     = r_wdata;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_g        <= '0;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_line     <= '0;
            r_dv       <= '0;
            r_inv      <= '0;
            r_inv_addr <= '0;
            r_own_vld  <= 1'b0;
            r_own      <= '0;
            r_ack      <= '0;
`ifdef HBC_RR_ARB_EN
            r_ptr      <= '0;
`endif
        end else begin
            r_dv  <= '0;
            r_inv <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_line_vld) begin
                        // Write wins when a hart raises both; its read is taken in a later round.
                        r_g     <= w_line_g;
                        r_op_wr <= h_wr[w_line_g];
                        r_addr  <= w_req_addr;
                        r_wdata <= h_data_out[LINE_W*int'(w_line_g) +: LINE_W];
                        r_rd    <= ~h_wr[w_line_g];
                        r_wr    <= h_wr[w_line_g];
                        r_state <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (m_ack) begin
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_dv    <= f_oh(r_g);
                        if (r_op_wr) begin
                            r_inv      <= ~f_oh(r_g);
                            r_inv_addr <= r_addr;
                        end else begin
                            r_line <= m_rdata;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_GAP;
                default: r_state <= S_IDLE;
            endcase

            if (w_amo_grant) begin
                r_own_vld <= 1'b1;
                r_own     <= w_amo_g;
                r_ack     <= f_oh(w_amo_g);
            end else if (r_own_vld && !h_amo_req[r_own]) begin
                r_own_vld <= 1'b0;
                r_ack     <= '0;
            end

`ifdef HBC_RR_ARB_EN
            if (r_state == S_IDLE && w_line_vld) begin
                r_ptr <= IDX_W'((int'(w_line_g) + 1) % NHART);
            end else if (w_amo_grant) begin
                r_ptr <= IDX_W'((int'(w_amo_g) + 1) % NHART);
            end
`endif
        end
    end

endmodule
